// File: rtl/adc_sample_ctrl.sv
// ADC request/ready sequencer: periodic conversion requests, byte capture with
// request timestamp, and missed/late conversion accounting for the trigger cache.
//
// state     | meaning
// IDLE      | stopped; timer holds, waiting for start
// WAIT_TICK | running; waiting for the period tick to raise req
// WAIT_RDY  | req high; waiting for rdy or the wait timeout
module adc_sample_ctrl #(
  parameter int unsigned DIV     = 16,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        rdy,
  input  logic [7:0]  adc_dat,
  output logic        req,
  output logic [7:0]  sample,
  output logic        sample_vld,
  output logic [31:0] sample_tm,
  output logic        running,
  output logic        timeout_err,
  output logic [7:0]  miss_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    WAIT_RDY  = 2'd2
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [31:0] timer, timer_nxt;
  logic [31:0] pend_tm, pend_tm_nxt;
  logic [31:0] sample_tm_nxt;
  logic [15:0] per_cnt, per_cnt_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic [7:0]  sample_nxt;
  logic [7:0]  miss_cnt_nxt;
  logic        req_nxt;
  logic        sample_vld_nxt;
  logic        timeout_err_nxt;
  logic        tick;
  logic [1:0]  miss_inc;

  assign running = (state != IDLE);
  assign tick    = running && (per_cnt == DIV_LAST);

  // A timeout and an overrun on the same edge add two misses at once.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  always_comb begin
    state_nxt       = state;
    timer_nxt       = timer;
    pend_tm_nxt     = pend_tm;
    sample_tm_nxt   = sample_tm;
    per_cnt_nxt     = per_cnt;
    wait_cnt_nxt    = wait_cnt;
    sample_nxt      = sample;
    miss_cnt_nxt    = miss_cnt;
    req_nxt         = req;
    sample_vld_nxt  = 1'b0;
    timeout_err_nxt = timeout_err;
    miss_inc        = 2'd0;

    if (running) begin
      timer_nxt   = timer + 32'd1;
      per_cnt_nxt = tick ? 16'd0 : per_cnt + 16'd1;
    end

    case (state)
      IDLE: begin
        if (start && !stop) begin
          timer_nxt       = 32'd0;
          per_cnt_nxt     = 16'd0;
          miss_cnt_nxt    = 8'd0;
          timeout_err_nxt = 1'b0;
          state_nxt       = WAIT_TICK;
        end
      end

      WAIT_TICK: begin
        if (stop) begin
          req_nxt   = 1'b0;
          state_nxt = IDLE;
        end else if (tick) begin
          req_nxt      = 1'b1;
          pend_tm_nxt  = timer;
          wait_cnt_nxt = 8'd0;
          state_nxt    = WAIT_RDY;
        end
      end

      WAIT_RDY: begin
        if (stop) begin
          req_nxt   = 1'b0;
          state_nxt = IDLE;
        end else begin
          miss_inc = {1'b0, tick};
          if (rdy) begin
            sample_nxt     = adc_dat;
            sample_tm_nxt  = pend_tm;
            sample_vld_nxt = 1'b1;
            req_nxt        = 1'b0;
            state_nxt      = WAIT_TICK;
          end else if (wait_cnt == TMO_LAST) begin
            req_nxt         = 1'b0;
            timeout_err_nxt = 1'b1;
            miss_inc        = miss_inc + 2'd1;
            state_nxt       = WAIT_TICK;
          end else begin
            wait_cnt_nxt = wait_cnt + 8'd1;
          end
          miss_cnt_nxt = sat_add(miss_cnt, miss_inc);
        end
      end

      default: begin
        req_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= 32'd0;
      pend_tm     <= 32'd0;
      sample_tm   <= 32'd0;
      per_cnt     <= 16'd0;
      wait_cnt    <= 8'd0;
      sample      <= 8'd0;
      miss_cnt    <= 8'd0;
      req         <= 1'b0;
      sample_vld  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      pend_tm     <= pend_tm_nxt;
      sample_tm   <= sample_tm_nxt;
      per_cnt     <= per_cnt_nxt;
      wait_cnt    <= wait_cnt_nxt;
      sample      <= sample_nxt;
      miss_cnt    <= miss_cnt_nxt;
      req         <= req_nxt;
      sample_vld  <= sample_vld_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Bench for adc_sample_ctrl: two instances (DIV=16/TIMEOUT=8, DIV=4/TIMEOUT=8)
// share stimulus; directed scenarios plus random traffic against an edge-count model.
module tb_adc_sample_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       rdy;
  logic [7:0] adc_dat;

  logic        req_o  [2];
  logic [7:0]  samp_o [2];
  logic        vld_o  [2];
  logic [31:0] tm_o   [2];
  logic        run_o  [2];
  logic        terr_o [2];
  logic [7:0]  miss_o [2];

  int errors = 0;
  int checks = 0;

  adc_sample_ctrl #(.DIV(16), .TIMEOUT(8)) u_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .rdy(rdy), .adc_dat(adc_dat),
    .req(req_o[0]), .sample(samp_o[0]), .sample_vld(vld_o[0]), .sample_tm(tm_o[0]),
    .running(run_o[0]), .timeout_err(terr_o[0]), .miss_cnt(miss_o[0])
  );

  adc_sample_ctrl #(.DIV(4), .TIMEOUT(8)) u_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .rdy(rdy), .adc_dat(adc_dat),
    .req(req_o[1]), .sample(samp_o[1]), .sample_vld(vld_o[1]), .sample_tm(tm_o[1]),
    .running(run_o[1]), .timeout_err(terr_o[1]), .miss_cnt(miss_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: edges since start, ticks at multiples of the period,
  // a transaction is alive from its request edge until rdy or TIMEOUT edges later.
  bit          m_run  [2];
  int unsigned m_k    [2];
  int unsigned m_kr   [2];
  bit          m_pend [2];
  logic [31:0] m_timer[2];
  logic [31:0] m_ptm  [2];
  logic [31:0] m_stm  [2];
  logic [7:0]  m_samp [2];
  int          m_miss [2];
  bit          m_terr [2];
  bit          m_vld  [2];
  int unsigned mk_now;
  int unsigned m_div;
  bit          m_tick;
  int          m_inc;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_div  = (i == 0) ? 16 : 4;
      m_vld[i] = 1'b0;
      if (reset) begin
        m_run[i] = 0; m_k[i] = 0; m_kr[i] = 0; m_pend[i] = 0;
        m_timer[i] = '0; m_ptm[i] = '0; m_stm[i] = '0; m_samp[i] = '0;
        m_miss[i] = 0; m_terr[i] = 0;
      end else if (!m_run[i]) begin
        if (start && !stop) begin
          m_run[i] = 1; m_k[i] = 0; m_timer[i] = '0; m_miss[i] = 0; m_terr[i] = 0;
        end
      end else begin
        mk_now = m_k[i] + 1;
        m_k[i] = mk_now;
        m_tick = (mk_now % m_div) == 0;
        if (stop) begin
          m_run[i]  = 0;
          m_pend[i] = 0;
        end else if (m_pend[i]) begin
          m_inc = m_tick ? 1 : 0;
          if (rdy) begin
            m_samp[i] = adc_dat;
            m_stm[i]  = m_ptm[i];
            m_vld[i]  = 1'b1;
            m_pend[i] = 0;
          end else if (mk_now - m_kr[i] == 8) begin
            m_pend[i] = 0;
            m_terr[i] = 1;
            m_inc     = m_inc + 1;
          end
          m_miss[i] = (m_miss[i] + m_inc > 255) ? 255 : m_miss[i] + m_inc;
        end else if (m_tick) begin
          m_pend[i] = 1;
          m_kr[i]   = mk_now;
          m_ptm[i]  = m_timer[i];
        end
        m_timer[i] = m_timer[i] + 32'd1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; rdy = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; stop = 1'b0; rdy = 1'b1; adc_dat = 8'hA5;
    for (int e = 0; e < 3; e++) begin
      cyc();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (req_o[i] !== 1'b0 || samp_o[i] !== 8'h00 || vld_o[i] !== 1'b0 || tm_o[i] !== 32'd0 ||
            run_o[i] !== 1'b0 || terr_o[i] !== 1'b0 || miss_o[i] !== 8'd0) begin
          errors++;
          $display("FAIL reset_state inst %0d edge %0d: got req=%b smp=%h vld=%b tm=%0d run=%b terr=%b miss=%0d want all zero",
                   i, e, req_o[i], samp_o[i], vld_o[i], tm_o[i], run_o[i], terr_o[i], miss_o[i]);
        end
      end
    end
    reset = 1'b0; start = 1'b0; rdy = 1'b0;
  endtask

  task automatic test_nominal();
    int  r;
    bit  prev;
    logic exp_req;
    logic exp_vld;
    do_reset();
    r = -100; prev = 0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int n = 1; n <= 36; n++) begin
      cyc();
      exp_req = (n >= 16 && n <= 18) || (n >= 32 && n <= 34);
      exp_vld = (n == 19) || (n == 35);
      checks++;
      if (req_o[0] !== exp_req) begin
        errors++; $display("FAIL nominal_req edge %0d: got %b want %b", n, req_o[0], exp_req);
      end
      checks++;
      if (vld_o[0] !== exp_vld) begin
        errors++; $display("FAIL nominal_vld edge %0d: got %b want %b", n, vld_o[0], exp_vld);
      end
      if (n == 19 || n == 35) begin
        checks++;
        if (samp_o[0] !== 8'hD4 || tm_o[0] !== ((n == 19) ? 32'd15 : 32'd31)) begin
          errors++; $display("FAIL nominal_capture edge %0d: got smp=%h tm=%0d want D4 tm=%0d",
                             n, samp_o[0], tm_o[0], (n == 19) ? 15 : 31);
        end
      end
      if (req_o[0] && !prev) r = n;
      prev = req_o[0];
      rdy = (n + 1 == r + 3);
      adc_dat = rdy ? 8'hD4 : 8'($urandom);
    end
    rdy = 1'b0;
    checks++;
    if (miss_o[0] !== 8'd0 || terr_o[0] !== 1'b0) begin
      errors++; $display("FAIL nominal_no_miss: got miss=%0d terr=%b want 0 0", miss_o[0], terr_o[0]);
    end
  endtask

  task automatic test_timeout();
    logic exp_req;
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      cyc();
      exp_req = (n >= 16 && n <= 23) || (n == 32);
      checks++;
      if (req_o[0] !== exp_req || vld_o[0] !== 1'b0) begin
        errors++; $display("FAIL timeout_req edge %0d: got req=%b vld=%b want req=%b vld=0", n, req_o[0], vld_o[0], exp_req);
      end
      if (n >= 24) begin
        checks++;
        if (terr_o[0] !== 1'b1 || miss_o[0] !== 8'd1) begin
          errors++; $display("FAIL timeout_flag edge %0d: got terr=%b miss=%0d want 1 1", n, terr_o[0], miss_o[0]);
        end
      end
      if (n == 11 || n == 12) begin
        checks++;
        if (miss_o[1] !== ((n == 11) ? 8'd1 : 8'd3)) begin
          errors++; $display("FAIL timeout_overrun_double edge %0d: got miss=%0d want %0d", n, miss_o[1], (n == 11) ? 1 : 3);
        end
      end
    end
    repeat (300 * 16) cyc();
    checks++;
    if (miss_o[0] !== 8'd255 || miss_o[1] !== 8'd255 || terr_o[0] !== 1'b1) begin
      errors++; $display("FAIL timeout_saturate: got miss_a=%0d miss_b=%0d terr=%b want 255 255 1", miss_o[0], miss_o[1], terr_o[0]);
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    checks++;
    if (miss_o[0] !== 8'd0 || terr_o[0] !== 1'b0 || run_o[0] !== 1'b1) begin
      errors++; $display("FAIL timeout_restart_clear: got miss=%0d terr=%b run=%b want 0 0 1", miss_o[0], terr_o[0], run_o[0]);
    end
  endtask

  task automatic test_overrun();
    int   r;
    bit   prev;
    logic exp_req;
    logic [7:0] cap_dat;
    do_reset();
    r = -100; prev = 0; cap_dat = 8'h00;
    start = 1'b1; cyc(); start = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      cyc();
      exp_req = (n >= 4 && n <= 9);
      checks++;
      if (req_o[1] !== exp_req) begin
        errors++; $display("FAIL overrun_req edge %0d: got %b want %b", n, req_o[1], exp_req);
      end
      if (n == 7 || n == 8) begin
        checks++;
        if (miss_o[1] !== ((n == 7) ? 8'd0 : 8'd1)) begin
          errors++; $display("FAIL overrun_miss edge %0d: got %0d want %0d", n, miss_o[1], (n == 7) ? 0 : 1);
        end
      end
      if (n == 10) begin
        checks++;
        if (vld_o[1] !== 1'b1 || tm_o[1] !== 32'd3 || miss_o[1] !== 8'd1 || samp_o[1] !== cap_dat) begin
          errors++; $display("FAIL overrun_capture: got vld=%b tm=%0d miss=%0d smp=%h want 1 3 1 %h",
                             vld_o[1], tm_o[1], miss_o[1], samp_o[1], cap_dat);
        end
      end
      if (req_o[1] && !prev) r = n;
      prev = req_o[1];
      rdy = (n + 1 == r + 6);
      adc_dat = 8'($urandom);
      if (rdy) cap_dat = adc_dat;
    end
    rdy = 1'b0;
  endtask

  task automatic test_stop();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      if (n == 17) begin
        checks++;
        if (req_o[0] !== 1'b1) begin
          errors++; $display("FAIL stop_pre_req: got %b want 1", req_o[0]);
        end
        stop = 1'b1;
      end else if (n == 18) begin
        checks++;
        if (req_o[0] !== 1'b0 || run_o[0] !== 1'b0 || run_o[1] !== 1'b0) begin
          errors++; $display("FAIL stop_latency: got req=%b run_a=%b run_b=%b want 0 0 0", req_o[0], run_o[0], run_o[1]);
        end
        stop = 1'b0; rdy = 1'b1; adc_dat = 8'h5A;
      end else if (n == 19) begin
        checks++;
        if (vld_o[0] !== 1'b0 || samp_o[0] !== 8'h00 || req_o[0] !== 1'b0) begin
          errors++; $display("FAIL stop_rdy_ignored: got vld=%b smp=%h req=%b want 0 00 0", vld_o[0], samp_o[0], req_o[0]);
        end
        rdy = 1'b0;
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    checks++;
    if (run_o[0] !== 1'b0 || run_o[1] !== 1'b0) begin
      errors++; $display("FAIL sim_start_stop: got run_a=%b run_b=%b want 0 0", run_o[0], run_o[1]);
    end
    start = 1'b1; cyc(); start = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      cyc();
      start = (n == 4);
      rdy   = (n == 16);
      adc_dat = 8'h3C;
      if (n == 16) begin
        checks++;
        if (req_o[0] !== 1'b1) begin
          errors++; $display("FAIL sim_restart_ignored_req: got %b want 1", req_o[0]);
        end
      end
      if (n == 17) begin
        checks++;
        if (vld_o[0] !== 1'b1 || tm_o[0] !== 32'd15 || samp_o[0] !== 8'h3C) begin
          errors++; $display("FAIL sim_restart_timer: got vld=%b tm=%0d smp=%h want 1 15 3c", vld_o[0], tm_o[0], samp_o[0]);
        end
      end
      if (n == 32) begin
        checks++;
        if (req_o[0] !== 1'b1) begin
          errors++; $display("FAIL sim_wait_rdy_req: got %b want 1", req_o[0]);
        end
        reset = 1'b1;
      end
      if (n == 33) begin
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (req_o[i] !== 1'b0 || samp_o[i] !== 8'h00 || vld_o[i] !== 1'b0 || tm_o[i] !== 32'd0 ||
              run_o[i] !== 1'b0 || terr_o[i] !== 1'b0 || miss_o[i] !== 8'd0) begin
            errors++;
            $display("FAIL sim_reset_mid inst %0d: got req=%b smp=%h vld=%b tm=%0d run=%b terr=%b miss=%0d want all zero",
                     i, req_o[i], samp_o[i], vld_o[i], tm_o[i], run_o[i], terr_o[i], miss_o[i]);
          end
        end
        reset = 1'b0;
      end
    end
    start = 1'b0; rdy = 1'b0;
  endtask

  task automatic test_random();
    int dens;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      dens    = ((c / 500) % 3 == 0) ? 2 : (((c / 500) % 3 == 1) ? 5 : 12);
      reset   = ($urandom_range(0, 499) == 0);
      start   = ($urandom_range(0, 19) == 0);
      stop    = ($urandom_range(0, 79) == 0);
      rdy     = ($urandom_range(0, dens - 1) == 0);
      adc_dat = 8'($urandom);
      cyc();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (req_o[i] !== m_pend[i]) begin
          errors++; $display("FAIL rand_req inst %0d cyc %0d: got %b want %b", i, c, req_o[i], m_pend[i]);
        end
        checks++;
        if (vld_o[i] !== m_vld[i]) begin
          errors++; $display("FAIL rand_vld inst %0d cyc %0d: got %b want %b", i, c, vld_o[i], m_vld[i]);
        end
        checks++;
        if (samp_o[i] !== m_samp[i] || tm_o[i] !== m_stm[i]) begin
          errors++; $display("FAIL rand_sample inst %0d cyc %0d: got %h/%0d want %h/%0d", i, c, samp_o[i], tm_o[i], m_samp[i], m_stm[i]);
        end
        checks++;
        if (run_o[i] !== m_run[i]) begin
          errors++; $display("FAIL rand_running inst %0d cyc %0d: got %b want %b", i, c, run_o[i], m_run[i]);
        end
        checks++;
        if (terr_o[i] !== m_terr[i] || miss_o[i] !== 8'(m_miss[i])) begin
          errors++; $display("FAIL rand_miss inst %0d cyc %0d: got terr=%b miss=%0d want %b %0d", i, c, terr_o[i], miss_o[i], m_terr[i], m_miss[i]);
        end
      end
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0; rdy = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; rdy = 1'b0; adc_dat = 8'h00;
    test_reset();
    test_nominal();
    test_timeout();
    test_overrun();
    test_stop();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
